// File: rtl/ppu_fetch_arbiter_if.sv
// ppu_fetch_arbiter_if: bundles the BG-fetcher, sprite-fetcher and memory-port
// signals of the PPU fetch arbiter.
//   slave  : arbiter side (takes fetcher requests and memory data, drives grants and data)
//   master : environment side (fetchers plus memory port)
// Signal names keep their _in/_out suffixes from the arbiter's point of view.
interface ppu_fetch_arbiter_if;
  logic [15:0] bg_addr_in;
  logic        bg_addr_valid_in;
  logic [7:0]  bg_data_out;
  logic        bg_data_valid_out;
  logic        bg_pause_out;
  logic        spr_req_in;
  logic [15:0] spr_addr_in;
  logic        spr_addr_valid_in;
  logic        spr_grant_out;
  logic [7:0]  spr_data_out;
  logic        spr_data_valid_out;
  logic [15:0] mem_addr_out;
  logic        mem_addr_valid_out;
  logic [7:0]  mem_data_in;
  logic        mem_data_valid_in;
  logic        lcd_stall_out;

  modport slave (
    input  bg_addr_in, bg_addr_valid_in, spr_req_in, spr_addr_in, spr_addr_valid_in,
           mem_data_in, mem_data_valid_in,
    output bg_data_out, bg_data_valid_out, bg_pause_out, spr_grant_out, spr_data_out,
           spr_data_valid_out, mem_addr_out, mem_addr_valid_out, lcd_stall_out
  );

  modport master (
    output bg_addr_in, bg_addr_valid_in, spr_req_in, spr_addr_in, spr_addr_valid_in,
           mem_data_in, mem_data_valid_in,
    input  bg_data_out, bg_data_valid_out, bg_pause_out, spr_grant_out, spr_data_out,
           spr_data_valid_out, mem_addr_out, mem_addr_valid_out, lcd_stall_out
  );
endinterface

// File: rtl/ppu_fetch_arbiter.sv
// ppu_fetch_arbiter: shares the single PPU VRAM/OAM read port between the BG
// fetcher and the sprite fetcher during mode 3.
//   BG_OWN -> (DRAIN) -> SPR_OWN -> BG_OWN. DRAIN lets the BG fetcher finish an
//   in-flight access for up to DRAIN_MAX T-cycles, then forces the handover.
// Ports:
//   clk_in, rst_n_in (async, active-low), tclk_in (T-cycle enable),
//   line_start_in (mode-3 start pulse), bus (ppu_fetch_arbiter_if.slave),
//   spr_penalty_out (T-cycles outside BG_OWN this line).
// Optional feature: define STATS_EN to build the saturating sprite-penalty
// counter; without it spr_penalty_out is tied to 0.
module ppu_fetch_arbiter #(
  parameter int DRAIN_MAX = 4,
  parameter int PENALTY_W = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 tclk_in,
  input  logic                 line_start_in,
  ppu_fetch_arbiter_if.slave   bus,
  output logic [PENALTY_W-1:0] spr_penalty_out
);

  localparam int CNT_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

  typedef enum logic [1:0] {BG_OWN, DRAIN, SPR_OWN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             spr_own;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= BG_OWN;
      cnt_q   <= '0;
    end else if (tclk_in) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      BG_OWN: begin
        if (bus.spr_req_in) begin
          state_d = bus.bg_addr_valid_in ? DRAIN : SPR_OWN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        // A withdrawn request beats a finished or timed-out drain.
        if (!bus.spr_req_in)
          state_d = BG_OWN;
        else if (!bus.bg_addr_valid_in || cnt_q == CNT_W'(DRAIN_MAX - 1))
          state_d = SPR_OWN;
        else
          cnt_d = cnt_q + 1'b1;
      end
      SPR_OWN: begin
        // Never hand back while the sprite fetcher has an access in flight.
        if (!bus.spr_req_in && !bus.spr_addr_valid_in)
          state_d = BG_OWN;
      end
      default: state_d = BG_OWN;
    endcase
  end

  // BG keeps the port during DRAIN; only SPR_OWN routes the sprite side.
  assign spr_own = (state_q == SPR_OWN);

  assign bus.mem_addr_out       = spr_own ? bus.spr_addr_in : bus.bg_addr_in;
  assign bus.mem_addr_valid_out = spr_own ? bus.spr_addr_valid_in : bus.bg_addr_valid_in;

  assign bus.bg_data_valid_out  = !spr_own && bus.mem_data_valid_in;
  assign bus.bg_data_out        = bus.bg_data_valid_out ? bus.mem_data_in : 8'hFF;
  assign bus.spr_data_valid_out = spr_own && bus.mem_data_valid_in;
  assign bus.spr_data_out       = bus.spr_data_valid_out ? bus.mem_data_in : 8'hFF;

  assign bus.bg_pause_out  = (state_q != BG_OWN);
  assign bus.spr_grant_out = spr_own;
  assign bus.lcd_stall_out = bus.bg_pause_out;

`ifdef STATS_EN
  logic [PENALTY_W-1:0] pen_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      pen_q <= '0;
    else if (tclk_in) begin
      if (line_start_in)
        pen_q <= '0;
      else if (state_q != BG_OWN && pen_q != {PENALTY_W{1'b1}})
        pen_q <= pen_q + 1'b1;
    end
  end

  assign spr_penalty_out = pen_q;
`else
  logic unused_line_start;
  assign unused_line_start = line_start_in;
  assign spr_penalty_out   = '0;
`endif

endmodule

// File: tb/tb_ppu_fetch_arbiter.sv
module tb_ppu_fetch_arbiter;
  logic       clk, rst_n, tclk, line_start;
  logic [7:0] pen;
  int         cmp_cnt = 0;
  int         err_cnt = 0;

  ppu_fetch_arbiter_if bus();

  ppu_fetch_arbiter #(.DRAIN_MAX(4), .PENALTY_W(8)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .tclk_in(tclk), .line_start_in(line_start),
    .bus(bus), .spr_penalty_out(pen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    bus.bg_addr_in = 16'h0000; bus.bg_addr_valid_in = 1'b0;
    bus.spr_req_in = 1'b0; bus.spr_addr_in = 16'h0000; bus.spr_addr_valid_in = 1'b0;
    bus.mem_data_in = 8'h00; bus.mem_data_valid_in = 1'b0;
    line_start = 1'b0; tclk = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    cmp_cnt++; if (bus.bg_data_out !== 8'hFF) begin err_cnt++; $display("FAIL rst_bg_data got %h want ff", bus.bg_data_out); end
    cmp_cnt++; if (bus.spr_data_out !== 8'hFF) begin err_cnt++; $display("FAIL rst_spr_data got %h want ff", bus.spr_data_out); end
    cmp_cnt++; if ({bus.bg_pause_out, bus.spr_grant_out, bus.lcd_stall_out, bus.bg_data_valid_out, bus.spr_data_valid_out, bus.mem_addr_valid_out} !== 6'b0)
      begin err_cnt++; $display("FAIL rst_flags got %b want 000000", {bus.bg_pause_out, bus.spr_grant_out, bus.lcd_stall_out, bus.bg_data_valid_out, bus.spr_data_valid_out, bus.mem_addr_valid_out}); end
    cmp_cnt++; if (bus.mem_addr_out !== 16'h0000) begin err_cnt++; $display("FAIL rst_mem_addr got %h want 0000", bus.mem_addr_out); end
    cmp_cnt++; if (pen !== 8'd0) begin err_cnt++; $display("FAIL rst_penalty got %0d want 0", pen); end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_bg_pass();
    bus.bg_addr_in = 16'h9800; bus.bg_addr_valid_in = 1'b1;
    bus.spr_addr_in = 16'hFE00; bus.spr_addr_valid_in = 1'b1; // ignored, not owner
    bus.mem_data_in = 8'hA5; bus.mem_data_valid_in = 1'b1;
    #1;
    cmp_cnt++; if (bus.mem_addr_out !== 16'h9800 || bus.mem_addr_valid_out !== 1'b1)
      begin err_cnt++; $display("FAIL bg_mem_addr got %h/%b want 9800/1", bus.mem_addr_out, bus.mem_addr_valid_out); end
    cmp_cnt++; if (bus.bg_data_out !== 8'hA5 || bus.bg_data_valid_out !== 1'b1)
      begin err_cnt++; $display("FAIL bg_data got %h/%b want a5/1", bus.bg_data_out, bus.bg_data_valid_out); end
    cmp_cnt++; if (bus.spr_data_out !== 8'hFF || bus.spr_data_valid_out !== 1'b0 || bus.bg_pause_out !== 1'b0)
      begin err_cnt++; $display("FAIL bg_nonowner got %h/%b pause %b want ff/0 pause 0", bus.spr_data_out, bus.spr_data_valid_out, bus.bg_pause_out); end
    bus.mem_data_valid_in = 1'b0; #1;
    cmp_cnt++; if (bus.bg_data_out !== 8'hFF || bus.bg_data_valid_out !== 1'b0)
      begin err_cnt++; $display("FAIL bg_nodata got %h/%b want ff/0", bus.bg_data_out, bus.bg_data_valid_out); end
    tick();
    idle_inputs();
  endtask

  task automatic test_spr_grant();
    bus.bg_addr_in = 16'h9800; bus.bg_addr_valid_in = 1'b0;
    bus.spr_req_in = 1'b1; bus.spr_addr_in = 16'hFE10; bus.spr_addr_valid_in = 1'b1;
    #1;
    cmp_cnt++; if (bus.spr_grant_out !== 1'b0 || bus.mem_addr_out !== 16'h9800)
      begin err_cnt++; $display("FAIL grant_before got %b/%h want 0/9800", bus.spr_grant_out, bus.mem_addr_out); end
    tick();
    cmp_cnt++; if ({bus.spr_grant_out, bus.bg_pause_out, bus.lcd_stall_out} !== 3'b111)
      begin err_cnt++; $display("FAIL grant_after got %b want 111", {bus.spr_grant_out, bus.bg_pause_out, bus.lcd_stall_out}); end
    cmp_cnt++; if (bus.mem_addr_out !== 16'hFE10 || bus.spr_data_out !== 8'hFF || bus.spr_data_valid_out !== 1'b0)
      begin err_cnt++; $display("FAIL spr_nodata got %h/%h/%b want fe10/ff/0", bus.mem_addr_out, bus.spr_data_out, bus.spr_data_valid_out); end
    bus.mem_data_in = 8'h3C; bus.mem_data_valid_in = 1'b1; #1;
    cmp_cnt++; if (bus.spr_data_out !== 8'h3C || bus.spr_data_valid_out !== 1'b1 || bus.bg_data_out !== 8'hFF || bus.bg_data_valid_out !== 1'b0)
      begin err_cnt++; $display("FAIL spr_data got %h/%b bg %h/%b want 3c/1 bg ff/0", bus.spr_data_out, bus.spr_data_valid_out, bus.bg_data_out, bus.bg_data_valid_out); end
    // Request drops while the sprite access is still in flight: keep the port.
    bus.spr_req_in = 1'b0;
    tick();
    cmp_cnt++; if (bus.spr_grant_out !== 1'b1)
      begin err_cnt++; $display("FAIL spr_midaccess got %b want 1", bus.spr_grant_out); end
    bus.spr_addr_valid_in = 1'b0; bus.mem_data_valid_in = 1'b0;
    tick();
    cmp_cnt++; if (bus.spr_grant_out !== 1'b0 || bus.bg_pause_out !== 1'b0 || bus.mem_addr_out !== 16'h9800)
      begin err_cnt++; $display("FAIL spr_release got %b/%b/%h want 0/0/9800", bus.spr_grant_out, bus.bg_pause_out, bus.mem_addr_out); end
    idle_inputs();
  endtask

  task automatic test_drain();
    bus.bg_addr_in = 16'h8010; bus.bg_addr_valid_in = 1'b1;
    bus.spr_req_in = 1'b1; bus.spr_addr_in = 16'hFE20; bus.spr_addr_valid_in = 1'b1;
    tick(); // -> DRAIN
    cmp_cnt++; if (bus.bg_pause_out !== 1'b1 || bus.spr_grant_out !== 1'b0 || bus.mem_addr_out !== 16'h8010)
      begin err_cnt++; $display("FAIL drain1 got %b/%b/%h want 1/0/8010", bus.bg_pause_out, bus.spr_grant_out, bus.mem_addr_out); end
    tick(); // BG still in flight -> stay
    cmp_cnt++; if (bus.spr_grant_out !== 1'b0 || bus.mem_addr_out !== 16'h8010)
      begin err_cnt++; $display("FAIL drain2 got %b/%h want 0/8010", bus.spr_grant_out, bus.mem_addr_out); end
    bus.bg_addr_valid_in = 1'b0;
    tick(); // BG done -> SPR_OWN
    cmp_cnt++; if (bus.spr_grant_out !== 1'b1 || bus.mem_addr_out !== 16'hFE20)
      begin err_cnt++; $display("FAIL drain_done got %b/%h want 1/fe20", bus.spr_grant_out, bus.mem_addr_out); end
    idle_inputs(); tick();
  endtask

  task automatic test_timeout();
    bus.bg_addr_in = 16'h9C00; bus.bg_addr_valid_in = 1'b1;
    bus.spr_req_in = 1'b1; bus.spr_addr_in = 16'hFE30; bus.spr_addr_valid_in = 1'b1;
    bus.mem_data_in = 8'h5A; bus.mem_data_valid_in = 1'b1;
    tick(); // enter DRAIN, count 0
    tick(3); // counts 1..3, still draining
    cmp_cnt++; if (bus.spr_grant_out !== 1'b0 || bus.bg_pause_out !== 1'b1)
      begin err_cnt++; $display("FAIL timeout_early got %b/%b want 0/1", bus.spr_grant_out, bus.bg_pause_out); end
    tick(); // 4th T-cycle in DRAIN forces handover
    cmp_cnt++; if (bus.spr_grant_out !== 1'b1 || bus.mem_addr_out !== 16'hFE30)
      begin err_cnt++; $display("FAIL timeout_grant got %b/%h want 1/fe30", bus.spr_grant_out, bus.mem_addr_out); end
    cmp_cnt++; if (bus.bg_data_valid_out !== 1'b0 || bus.bg_data_out !== 8'hFF)
      begin err_cnt++; $display("FAIL timeout_bgdrop got %b/%h want 0/ff", bus.bg_data_valid_out, bus.bg_data_out); end
    idle_inputs(); tick();
  endtask

  task automatic test_withdraw();
    bus.bg_addr_valid_in = 1'b1; bus.spr_req_in = 1'b1;
    tick(); // DRAIN
    bus.bg_addr_valid_in = 1'b0; bus.spr_req_in = 1'b0; // both true: withdraw wins
    tick();
    cmp_cnt++; if (bus.spr_grant_out !== 1'b0 || bus.bg_pause_out !== 1'b0)
      begin err_cnt++; $display("FAIL withdraw got %b/%b want 0/0", bus.spr_grant_out, bus.bg_pause_out); end
    idle_inputs();
  endtask

  task automatic test_tclk_hold();
    tclk = 1'b0; bus.spr_req_in = 1'b1;
    tick(2);
    cmp_cnt++; if (bus.spr_grant_out !== 1'b0)
      begin err_cnt++; $display("FAIL tclk_hold got %b want 0", bus.spr_grant_out); end
    bus.bg_addr_in = 16'h9901; #1;
    cmp_cnt++; if (bus.mem_addr_out !== 16'h9901)
      begin err_cnt++; $display("FAIL tclk_comb got %h want 9901", bus.mem_addr_out); end
    tclk = 1'b1;
    tick();
    cmp_cnt++; if (bus.spr_grant_out !== 1'b1)
      begin err_cnt++; $display("FAIL tclk_resume got %b want 1", bus.spr_grant_out); end
  endtask

  // Entered in SPR_OWN from test_tclk_hold with spr_req_in still high.
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      bus.spr_addr_valid_in = i[0];
      tick();
      cmp_cnt++; if (bus.spr_grant_out !== 1'b1 || bus.bg_pause_out !== 1'b1)
        begin err_cnt++; $display("FAIL b2b_%0d got %b/%b want 1/1", i, bus.spr_grant_out, bus.bg_pause_out); end
    end
    idle_inputs(); tick();
  endtask

  task automatic test_reset_midaccess();
    bus.spr_req_in = 1'b1; bus.spr_addr_valid_in = 1'b1;
    tick();
    #2 rst_n = 1'b0; #1;
    cmp_cnt++; if (bus.spr_grant_out !== 1'b0 || bus.bg_pause_out !== 1'b0)
      begin err_cnt++; $display("FAIL rst_mid got %b/%b want 0/0", bus.spr_grant_out, bus.bg_pause_out); end
    idle_inputs();
    @(negedge clk); rst_n = 1'b1;
    tick();
    cmp_cnt++; if (bus.spr_grant_out !== 1'b0)
      begin err_cnt++; $display("FAIL rst_nograbt got %b want 0", bus.spr_grant_out); end
  endtask

  task automatic test_penalty();
    line_start = 1'b1; tick(); line_start = 1'b0;
    bus.spr_req_in = 1'b1;
    tick();    // BG_OWN -> SPR_OWN, no count yet
    tick(5);   // 5 edges in SPR_OWN
    bus.spr_req_in = 1'b0;
    tick();    // 6th edge in SPR_OWN, back to BG_OWN
`ifdef STATS_EN
    cmp_cnt++; if (pen !== 8'd6) begin err_cnt++; $display("FAIL pen_6 got %0d want 6", pen); end
    line_start = 1'b1; tick(); line_start = 1'b0;
    cmp_cnt++; if (pen !== 8'd0) begin err_cnt++; $display("FAIL pen_clear got %0d want 0", pen); end
    bus.spr_req_in = 1'b1;
    tick(300);
    cmp_cnt++; if (pen !== 8'd255) begin err_cnt++; $display("FAIL pen_sat got %0d want 255", pen); end
    line_start = 1'b1; tick(); line_start = 1'b0; // clear beats increment
    cmp_cnt++; if (pen !== 8'd0) begin err_cnt++; $display("FAIL pen_clrwin got %0d want 0", pen); end
`else
    cmp_cnt++; if (pen !== 8'd0) begin err_cnt++; $display("FAIL pen_off got %0d want 0", pen); end
`endif
    idle_inputs(); tick();
  endtask

  initial begin
    test_reset();
    test_bg_pass();
    test_spr_grant();
    test_drain();
    test_timeout();
    test_withdraw();
    test_tclk_hold();
    test_back_to_back();
    test_reset_midaccess();
    test_penalty();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
